// File: rtl/data_stream_demultiplexer.sv
// De-interleaves a word stream carrying 1..3 streams per symbol frame into
// registered ds1..ds3, flagging short frames and surplus words.
module data_stream_demultiplexer #(
    parameter int unsigned clk_f        = 100_000_000,
    parameter int unsigned symbol_clk_f = 1_000_000,
    parameter int unsigned ds_width     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                symbol_clk,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    input  logic [ds_width-1:0] multiplexed_data,
    output logic [ds_width-1:0] ds1,
    output logic [ds_width-1:0] ds2,
    output logic [ds_width-1:0] ds3,
    output logic                out_valid,
    output logic                frame_error,
    output logic                overflow
);

    localparam int unsigned clk_per_symbol = clk_f / symbol_clk_f;

    generate
        if (clk_per_symbol < 8) begin : g_ratio_check
            $error("data_stream_demultiplexer: clk_f/symbol_clk_f must be >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Frame marker synchroniser and edge detector
    // ------------------------------------------------------------------
    logic sync1_reg;
    logic sync2_reg;
    logic hist_reg;
    logic fill1_reg;
    logic fill2_reg;
    logic armed_reg;
    logic frame_start;

    // armed only after a genuine low has been seen, so a marker that is
    // already high when reset releases does not open a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= 1'b0;
            fill1_reg <= 1'b0;
            fill2_reg <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            sync1_reg <= symbol_clk;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
            fill1_reg <= 1'b1;
            fill2_reg <= fill1_reg;
            if (fill2_reg && !sync2_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign frame_start = sync2_reg & ~hist_reg & armed_reg;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t              state_reg;
    state_t              state_next;
    logic [1:0]          idx_reg;
    logic [1:0]          idx_next;
    logic [1:0]          active_n_reg;
    logic [1:0]          eff_n;
    logic [1:0]          base_idx;
    logic                collecting;
    logic                accept;
    logic                done;
    logic                error_next;
    logic                overflow_next;
    logic                commit_reg;
    logic [1:0]          commit_n_reg;
    logic                out_valid_reg;
    logic                frame_error_reg;
    logic                overflow_reg;

    // A frame_start in the same cycle as a word re-targets that word to
    // slot 0 of the new frame, counted against the newly sampled mode.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        eff_n      = active_n_reg;
        base_idx   = idx_reg;
        collecting = (state_reg == COLLECT);
        if (frame_start) begin
            eff_n      = mode;
            base_idx   = 2'd0;
            collecting = (mode != 2'd0);
            idx_next   = 2'd0;
            state_next = (mode == 2'd0) ? IDLE : COLLECT;
        end
        accept = in_valid && collecting;
        done   = accept && ((base_idx + 2'd1) == eff_n);
        if (done) begin
            state_next = HOLD;
        end else if (accept) begin
            idx_next = base_idx + 2'd1;
        end
        error_next    = frame_start && (state_reg == COLLECT);
        overflow_next = in_valid && !frame_start && (state_reg == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= 2'd0;
            active_n_reg    <= 2'd0;
            commit_reg      <= 1'b0;
            commit_n_reg    <= 2'd0;
            out_valid_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            if (frame_start) begin
                active_n_reg <= mode;
            end
            commit_reg      <= done;
            if (done) begin
                commit_n_reg <= eff_n;
            end
            out_valid_reg   <= commit_reg;
            frame_error_reg <= error_next;
            overflow_reg    <= overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Shadow slots and published stream words
    // ------------------------------------------------------------------
    logic [ds_width-1:0]       shadow_reg [3];
    logic [ds_width-1:0]       ds_reg     [3];
    logic [2:0]                slot_load;
    logic [2:0][ds_width-1:0]  pub_val;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            assign slot_load[gi] = accept && (base_idx == 2'(gi));
            // slots beyond the frame's stream count publish as zero
            assign pub_val[gi]   = (2'(gi) < commit_n_reg) ? shadow_reg[gi] : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                shadow_reg[i] <= '0;
                ds_reg[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (slot_load[i]) begin
                    shadow_reg[i] <= multiplexed_data;
                end
                if (commit_reg) begin
                    ds_reg[i] <= pub_val[i];
                end
            end
        end
    end

    assign ds1         = ds_reg[0];
    assign ds2         = ds_reg[1];
    assign ds3         = ds_reg[2];
    assign out_valid   = out_valid_reg;
    assign frame_error = frame_error_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_data_stream_demultiplexer.sv
// Bench for data_stream_demultiplexer: frame-level reference model compared
// every cycle, directed scenarios pinned with literal values, random frames.
module tb_data_stream_demultiplexer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       symbol_clk = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       in_valid = 1'b0;
    logic [3:0] multiplexed_data = 4'd0;
    logic [3:0] ds1, ds2, ds3;
    logic       out_valid, frame_error, overflow;

    data_stream_demultiplexer #(
        .clk_f(100_000_000),
        .symbol_clk_f(1_000_000),
        .ds_width(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .symbol_clk(symbol_clk),
        .mode(mode),
        .in_valid(in_valid),
        .multiplexed_data(multiplexed_data),
        .ds1(ds1),
        .ds2(ds2),
        .ds3(ds3),
        .out_valid(out_valid),
        .frame_error(frame_error),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // values driven for the next clock edge
    bit         drv_s = 1'b0;
    logic [1:0] drv_m = 2'd0;
    bit         drv_v = 1'b0;
    logic [3:0] drv_d = 4'd0;

    // reference model: edges at which a frame opens, words of current frame
    int         fs_q[$];
    logic [3:0] words[$];
    int         m_n = 0;
    bit         m_collect = 1'b0;
    bit         m_hold = 1'b0;
    bit         pend = 1'b0;
    bit         in_rst = 1'b0;
    logic [3:0] pub[3] = '{default: 4'd0};
    logic [3:0] exp_ds[3] = '{default: 4'd0};
    bit         exp_ov = 1'b0;
    bit         exp_err = 1'b0;
    bit         exp_ovf = 1'b0;

    int ov_seen = 0;
    int err_seen = 0;
    int ovf_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        fs_q.delete();
        words.delete();
        m_n       = 0;
        m_collect = 1'b0;
        m_hold    = 1'b0;
        pend      = 1'b0;
        exp_ov    = 1'b0;
        exp_err   = 1'b0;
        exp_ovf   = 1'b0;
        for (int i = 0; i < 3; i++) exp_ds[i] = 4'd0;
    endtask

    // Outputs expected right after edge number cyc, from inputs sampled there.
    task automatic model_edge();
        bit fs;
        fs = (fs_q.size() > 0) && (fs_q[0] == cyc);
        if (fs) void'(fs_q.pop_front());
        if (in_rst) begin
            model_reset();
            return;
        end
        exp_ov = pend;
        if (pend) begin
            for (int i = 0; i < 3; i++) exp_ds[i] = pub[i];
        end
        pend    = 1'b0;
        exp_err = fs && m_collect;
        exp_ovf = drv_v && !fs && m_hold;
        if (fs) begin
            words.delete();
            m_n       = int'(drv_m);
            m_collect = (drv_m != 2'd0);
            m_hold    = 1'b0;
        end
        if (drv_v && m_collect) begin
            words.push_back(drv_d);
            if (words.size() == m_n) begin
                for (int i = 0; i < 3; i++) pub[i] = (i < m_n) ? words[i] : 4'd0;
                pend      = 1'b1;
                m_collect = 1'b0;
                m_hold    = 1'b1;
            end
        end
    endtask

    // Marker driven right after edge k is seen as a frame start at edge k+3.
    task automatic tick(input bit s, input logic [1:0] m, input bit v, input logic [3:0] d);
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        if (s && !drv_s && !rst) fs_q.push_back(cyc + 3);
        drv_s = s;
        drv_m = m;
        drv_v = v;
        drv_d = d;
        symbol_clk       = s;
        mode             = m;
        in_valid         = v;
        multiplexed_data = d;
    endtask

    always @(negedge clk) begin
        chk("ds1", {28'd0, ds1}, {28'd0, exp_ds[0]});
        chk("ds2", {28'd0, ds2}, {28'd0, exp_ds[1]});
        chk("ds3", {28'd0, ds3}, {28'd0, exp_ds[2]});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("frame_error", {31'd0, frame_error}, {31'd0, exp_err});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        if (out_valid === 1'b1) ov_seen++;
        if (frame_error === 1'b1) err_seen++;
        if (overflow === 1'b1) ovf_seen++;
    end

    task automatic clear_counts();
        ov_seen  = 0;
        err_seen = 0;
        ovf_seen = 0;
    endtask

    // Reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset(input bit s_hold);
        #2;
        rst = 1'b1;
        in_rst = 1'b1;
        model_reset();
        #1;
        chk("rst_ds1", {28'd0, ds1}, 32'd0);
        chk("rst_ds2", {28'd0, ds2}, 32'd0);
        chk("rst_ds3", {28'd0, ds3}, 32'd0);
        chk("rst_flags", {29'd0, out_valid, frame_error, overflow}, 32'd0);
        repeat (3) tick(s_hold, 2'd0, 1'b0, 4'd0);
        rst = 1'b0;
        in_rst = 1'b0;
    endtask

    // 12-cycle frame: marker high for 6, mode switches to m_late from tick 5,
    // n words at ticks first, first+gap, ... (tick 2 coincides with frame_start)
    task automatic run_frame(input logic [1:0] m, input logic [1:0] m_late, input int n,
                             input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input logic [3:0] w3,
                             input int first, input int gap);
        logic [3:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int t = 0; t < 12; t++) begin
            bit         v;
            logic [3:0] d;
            v = 1'b0;
            d = 4'($urandom);
            for (int k = 0; k < n; k++) begin
                if (t == first + k * gap) begin
                    v = 1'b1;
                    d = w[k];
                end
            end
            tick(t < 6, (t < 5) ? m : m_late, v, d);
        end
    endtask

    task automatic chk_ds(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c);
        chk({name, "_ds1"}, {28'd0, ds1}, {28'd0, a});
        chk({name, "_ds2"}, {28'd0, ds2}, {28'd0, b});
        chk({name, "_ds3"}, {28'd0, ds3}, {28'd0, c});
    endtask

    initial begin
        do_reset(1'b0);
        repeat (4) tick(1'b0, 2'd0, 1'b0, 4'd0);

        // three streams
        clear_counts();
        run_frame(2'd3, 2'd3, 3, 4'hA, 4'h5, 4'hC, 4'h0, 3, 1);
        chk_ds("m3", 4'hA, 4'h5, 4'hC);
        chk("m3_ov_count", ov_seen, 1);
        chk("m3_err_count", err_seen, 0);

        // one stream, surplus word
        clear_counts();
        run_frame(2'd1, 2'd1, 2, 4'h7, 4'h3, 4'h0, 4'h0, 3, 1);
        chk_ds("m1", 4'h7, 4'h0, 4'h0);
        chk("m1_ov_count", ov_seen, 1);
        chk("m1_ovf_count", ovf_seen, 1);

        // short frame: nothing published, values kept
        clear_counts();
        run_frame(2'd3, 2'd3, 2, 4'h1, 4'h2, 4'h0, 4'h0, 3, 1);
        chk("short_ov_count", ov_seen, 0);
        chk_ds("short", 4'h7, 4'h0, 4'h0);

        // error reported at the next start; word coincident with frame_start
        clear_counts();
        run_frame(2'd2, 2'd2, 2, 4'h9, 4'h4, 4'h0, 4'h0, 2, 1);
        chk("coinc_err_count", err_seen, 1);
        chk("coinc_ov_count", ov_seen, 1);
        chk_ds("coinc", 4'h9, 4'h4, 4'h0);

        // mode change mid-frame applies only from the next frame
        clear_counts();
        run_frame(2'd2, 2'd3, 2, 4'h6, 4'h8, 4'h0, 4'h0, 3, 1);
        chk("modechg_ov_count", ov_seen, 1);
        chk_ds("modechg", 4'h6, 4'h8, 4'h0);
        clear_counts();
        run_frame(2'd3, 2'd3, 2, 4'hB, 4'hD, 4'h0, 4'h0, 3, 1);
        chk("modechg2_ov_count", ov_seen, 0);
        clear_counts();
        run_frame(2'd3, 2'd3, 3, 4'h1, 4'h2, 4'h3, 4'h0, 3, 2);
        chk("modechg3_err_count", err_seen, 1);
        chk_ds("modechg3", 4'h1, 4'h2, 4'h3);

        // reset after one word of a frame
        for (int t = 0; t < 5; t++) tick(t < 6, 2'd3, t == 3, 4'h5);
        do_reset(1'b0);
        repeat (4) tick(1'b0, 2'd3, 1'b0, 4'd0);
        clear_counts();
        run_frame(2'd3, 2'd3, 3, 4'hE, 4'hF, 4'h1, 4'h0, 3, 1);
        chk_ds("postrst", 4'hE, 4'hF, 4'h1);
        chk("postrst_ov_count", ov_seen, 1);
        chk("postrst_err_count", err_seen, 0);

        // marker already high at reset release must not open a frame
        do_reset(1'b1);
        clear_counts();
        repeat (8) tick(1'b1, 2'd1, 1'b1, 4'h5);
        chk("hirel_ov_count", ov_seen, 0);
        chk("hirel_ovf_count", ovf_seen, 0);
        repeat (6) tick(1'b0, 2'd1, 1'b0, 4'd0);
        run_frame(2'd1, 2'd1, 1, 4'h2, 4'h0, 4'h0, 4'h0, 4, 1);
        chk("hirel2_ov_count", ov_seen, 1);
        chk_ds("hirel2", 4'h2, 4'h0, 4'h0);

        // random frames
        for (int f = 0; f < 40; f++) begin
            run_frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 4), 4'($urandom), 4'($urandom),
                      4'($urandom), 4'($urandom), $urandom_range(2, 5),
                      $urandom_range(1, 2));
        end
        repeat (6) tick(1'b0, 2'd0, 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
